// File: rtl/ram_mp_clr.sv
// Multi-read-port RAM with per-lane write enables, optional registered reads,
// write-first bypass and a one-word-per-cycle clear sweep that replaces an array reset.
module ram_mp_clr #(
    parameter int D_WIDTH  = 19,
    parameter int A_WIDTH  = 5,
    parameter int A_MAX    = 32,
    parameter int R_PORTS  = 2,
    parameter int LANE_W   = 8,
    parameter int REG_READ = 0,
    parameter int BYPASS   = 1,
    localparam int N_LANES = (D_WIDTH + LANE_W - 1) / LANE_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_req,
    output logic                         busy,
    input  logic                         write_enable,
    input  logic [A_WIDTH-1:0]           address_write,
    input  logic [D_WIDTH-1:0]           data_write,
    input  logic [N_LANES-1:0]           lane_enable,
    output logic                         wr_drop,
    input  logic [R_PORTS*A_WIDTH-1:0]   address_read,
    output logic [R_PORTS*D_WIDTH-1:0]   data_read
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Wider than the address so A_MAX == 2**A_WIDTH stays representable.
    localparam logic [A_WIDTH:0]   A_LIMIT  = (A_WIDTH+1)'(A_MAX);
    localparam logic [A_WIDTH-1:0] PTR_LAST = A_WIDTH'(A_MAX - 1);

    state_t               state_q, state_d;
    logic [A_WIDTH-1:0]   ptr_q, ptr_d;
    logic                 wr_drop_q, wr_drop_d;

    logic [D_WIDTH-1:0]   mem [A_MAX];
    logic [D_WIDTH-1:0]   lane_mask;
    logic [D_WIDTH-1:0]   wr_merged;
    logic [D_WIDTH-1:0]   rd_d [R_PORTS];
    logic                 busy_w;
    logic                 wr_in_range;
    logic                 wr_accept;

    assign busy_w      = (state_q == CLEAR);
    assign busy        = busy_w;
    assign wr_drop     = wr_drop_q;
    assign wr_in_range = ({1'b0, address_write} < A_LIMIT);
    assign wr_accept   = reset && !busy_w && write_enable && wr_in_range;

    for (genvar i = 0; i < D_WIDTH; i++) begin : g_mask
        assign lane_mask[i] = lane_enable[i / LANE_W];
    end

    assign wr_merged = (mem[address_write] & ~lane_mask) | (data_write & lane_mask);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_drop_d = write_enable && (busy_w || !wr_in_range);
        case (state_q)
            IDLE: begin
                if (clear_req) state_d = CLEAR;
            end
            CLEAR: begin
                if (ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= CLEAR;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Contents are deliberately unreset; only the sweep zeroes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (busy_w) begin
                mem[ptr_q] <= '0;
            end else if (wr_accept) begin
                mem[address_write] <= wr_merged;
            end
        end
    end

    always_comb begin
        logic [A_WIDTH-1:0] rd_addr;
        rd_addr = '0;
        for (int p = 0; p < R_PORTS; p++) begin
            rd_addr = address_read[p*A_WIDTH +: A_WIDTH];
            rd_d[p] = '0;
            if (!busy_w && ({1'b0, rd_addr} < A_LIMIT)) begin
                if (BYPASS != 0 && wr_accept && rd_addr == address_write) begin
                    rd_d[p] = wr_merged;
                end else begin
                    rd_d[p] = mem[rd_addr];
                end
            end
        end
    end

    if (REG_READ != 0) begin : g_reg
        logic [D_WIDTH-1:0] rd_q [R_PORTS];

        always_ff @(posedge clk) begin
            for (int p = 0; p < R_PORTS; p++) begin
                if (!reset) rd_q[p] <= '0;
                else        rd_q[p] <= rd_d[p];
            end
        end

        always_comb begin
            data_read = '0;
            for (int p = 0; p < R_PORTS; p++) data_read[p*D_WIDTH +: D_WIDTH] = rd_q[p];
        end
    end else begin : g_comb
        always_comb begin
            data_read = '0;
            for (int p = 0; p < R_PORTS; p++) data_read[p*D_WIDTH +: D_WIDTH] = rd_d[p];
        end
    end

endmodule

// File: tb/tb_ram_mp_clr.sv
// Bench for ram_mp_clr: three configurations (bypass, no bypass, registered read)
// share one stimulus stream and one array-level reference model.
module tb_ram_mp_clr;

    localparam int DW = 19;
    localparam int AW = 5;
    localparam int AM = 32;
    localparam int RP = 2;
    localparam int LW = 8;
    localparam int NL = (DW + LW - 1) / LW;

    logic               clk = 1'b0;
    logic               reset;
    logic               clear_req;
    logic               write_enable;
    logic [AW-1:0]      address_write;
    logic [DW-1:0]      data_write;
    logic [NL-1:0]      lane_enable;
    logic [RP*AW-1:0]   address_read;

    logic               busy_a, busy_b, busy_c;
    logic               drop_a, drop_b, drop_c;
    logic [RP*DW-1:0]   rd_a, rd_b, rd_c;

    always #5 clk = ~clk;

    ram_mp_clr #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(AM), .R_PORTS(RP), .LANE_W(LW),
                 .REG_READ(0), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy_a),
        .write_enable(write_enable), .address_write(address_write), .data_write(data_write),
        .lane_enable(lane_enable), .wr_drop(drop_a), .address_read(address_read), .data_read(rd_a));

    ram_mp_clr #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(AM), .R_PORTS(RP), .LANE_W(LW),
                 .REG_READ(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy_b),
        .write_enable(write_enable), .address_write(address_write), .data_write(data_write),
        .lane_enable(lane_enable), .wr_drop(drop_b), .address_read(address_read), .data_read(rd_b));

    ram_mp_clr #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(AM), .R_PORTS(RP), .LANE_W(LW),
                 .REG_READ(1), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy_c),
        .write_enable(write_enable), .address_write(address_write), .data_write(data_write),
        .lane_enable(lane_enable), .wr_drop(drop_c), .address_read(address_read), .data_read(rd_c));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] mmem [AM];
    bit            in_sweep  = 1'b1;
    int            sweep_pos = 0;
    bit            drop_exp  = 1'b0;
    logic [DW-1:0] reg_exp [RP];
    bit            chk_en    = 1'b0;

    // Last negedge samples
    bit            s_busy, s_drop;
    logic [DW-1:0] s_rd_a [RP];
    logic [DW-1:0] s_rd_b [RP];
    logic [DW-1:0] s_rd_c [RP];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [NL-1:0] le);
        logic [DW-1:0] r;
        r = old_w;
        for (int k = 0; k < NL; k++)
            if (le[k])
                for (int b = k * LW; b < (k + 1) * LW && b < DW; b++) r[b] = new_w[b];
        return r;
    endfunction

    function automatic bit accepted();
        return !in_sweep && reset && write_enable && int'(address_write) < AM;
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
        if (in_sweep || int'(a) >= AM) return '0;
        if (byp && accepted() && a == address_write)
            return merge(mmem[a], data_write, lane_enable);
        return mmem[a];
    endfunction

    task automatic step();
        logic [AW-1:0] ap;
        @(negedge clk);
        s_busy = busy_a;
        s_drop = drop_a;
        for (int p = 0; p < RP; p++) begin
            s_rd_a[p] = rd_a[p*DW +: DW];
            s_rd_b[p] = rd_b[p*DW +: DW];
            s_rd_c[p] = rd_c[p*DW +: DW];
        end
        if (chk_en) begin
            chk("busy_a", busy_a, in_sweep);
            chk("busy_b", busy_b, in_sweep);
            chk("busy_c", busy_c, in_sweep);
            chk("drop_a", drop_a, drop_exp);
            chk("drop_c", drop_c, drop_exp);
            for (int p = 0; p < RP; p++) begin
                ap = address_read[p*AW +: AW];
                chk("rd_bypass", s_rd_a[p], exp_read(ap, 1'b1));
                chk("rd_nobypass", s_rd_b[p], exp_read(ap, 1'b0));
                chk("rd_registered", s_rd_c[p], reg_exp[p]);
            end
        end
        @(posedge clk);
        if (!reset) begin
            in_sweep  = 1'b1;
            sweep_pos = 0;
            drop_exp  = 1'b0;
            for (int p = 0; p < RP; p++) reg_exp[p] = '0;
        end else begin
            for (int p = 0; p < RP; p++) reg_exp[p] = exp_read(address_read[p*AW +: AW], 1'b1);
            if (in_sweep) begin
                drop_exp = write_enable;
                mmem[sweep_pos] = '0;
                sweep_pos++;
                if (sweep_pos == AM) begin
                    in_sweep  = 1'b0;
                    sweep_pos = 0;
                end
            end else begin
                drop_exp = write_enable && int'(address_write) >= AM;
                if (accepted()) mmem[address_write] = merge(mmem[address_write], data_write, lane_enable);
                if (clear_req) in_sweep = 1'b1;
            end
        end
        chk_en = 1'b1;
        #1;
    endtask

    task automatic set_wr(input bit we, input int a, input logic [DW-1:0] d, input logic [NL-1:0] le);
        write_enable  = we;
        address_write = AW'(a);
        data_write    = d;
        lane_enable   = le;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            address_read = RP*AW'($urandom);
            step();
            if (s_busy) cnt++;
            else break;
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            step();
            if (!s_busy) break;
        end
        chk(tag, s_busy, 1'b0);
    endtask

    initial begin
        int cnt;
        reset = 1'b0;
        clear_req = 1'b0;
        set_wr(0, 0, '0, '0);
        address_read = '0;
        repeat (3) step();

        // T1: power-up sweep length, reads forced to zero meanwhile
        reset = 1'b1;
        count_busy(cnt);
        chk("t1_sweep_len", cnt, 32);

        // T2: lane merge
        set_wr(1, 5, 19'h7FFFF, 3'b111); step();
        set_wr(1, 5, 19'h00000, 3'b010); step();
        set_wr(0, 0, '0, '0);
        address_read = {AW'(0), AW'(5)};
        step();
        chk("t2_lane_merge", s_rd_a[0], 19'h700FF);

        // T3: same-cycle bypass vs pre-write contents
        set_wr(1, 9, 19'h12345, 3'b111);
        address_read = {AW'(9), AW'(0)};
        step();
        chk("t3_bypass", s_rd_a[1], 19'h12345);
        chk("t3_nobypass_old", s_rd_b[1], 19'h00000);
        set_wr(0, 0, '0, '0);
        step();
        chk("t3_nobypass_new", s_rd_b[1], 19'h12345);

        // T6: registered read, both ports on one address, address moved before the next edge
        set_wr(1, 3, 19'h00ABC, 3'b111); step();
        set_wr(0, 0, '0, '0);
        address_read = {AW'(3), AW'(3)};
        step();
        address_read = {AW'(20), AW'(21)};
        step();
        chk("t6_reg_p0", s_rd_c[0], 19'h00ABC);
        chk("t6_reg_p1", s_rd_c[1], 19'h00ABC);

        // T4: write during the 3rd busy cycle is dropped, sweep still clears the word
        set_wr(1, 7, 19'h5A5A5, 3'b111); step();
        set_wr(0, 0, '0, '0);
        clear_req = 1'b1; step();
        clear_req = 1'b0;
        step(); step();
        set_wr(1, 7, 19'h11111, 3'b111);
        step();
        chk("t4_busy_at_write", s_busy, 1'b1);
        set_wr(0, 0, '0, '0);
        step();
        chk("t4_drop_pulse", s_drop, 1'b1);
        step();
        chk("t4_drop_single", s_drop, 1'b0);
        wait_idle("t4_idle_timeout");
        address_read = {AW'(0), AW'(7)};
        step();
        chk("t4_cleared", s_rd_a[0], 19'h00000);

        // T5: clear_req mid-sweep ignored; reset mid-sweep restarts a full sweep
        clear_req = 1'b1; step();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            clear_req = (cnt == 10);
            step();
            if (s_busy) cnt++;
            else break;
        end
        clear_req = 1'b0;
        chk("t5_sweep_len_with_req", cnt, 32);
        clear_req = 1'b1; step();
        clear_req = 1'b0;
        repeat (20) step();
        reset = 1'b0; step(); step();
        reset = 1'b1;
        count_busy(cnt);
        chk("t5_sweep_len_after_reset", cnt, 32);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 249) != 0);
            clear_req = ($urandom_range(0, 79) == 0);
            set_wr($urandom_range(0, 2) != 0, $urandom_range(0, AM - 1), DW'($urandom),
                   NL'($urandom));
            for (int p = 0; p < RP; p++)
                address_read[p*AW +: AW] = ($urandom_range(0, 1) != 0) ? address_write : AW'($urandom);
            step();
        end
        reset = 1'b1;
        clear_req = 1'b0;
        set_wr(0, 0, '0, '0);
        wait_idle("final_idle_timeout");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
